// File: rtl/mc_chroma_ref_feeder_pkg.sv
// mc_chroma_ref_feeder_pkg: shared widths, row type and FSM states for the chroma reference feeder
package mc_chroma_ref_feeder_pkg;
  localparam int PIXEL_WIDTH = 8;
  localparam int REF_W = 20;
  localparam int ROW_W = REF_W * PIXEL_WIDTH;
  localparam int ADDR_W = 8;
  localparam int TAPS = 3;
  typedef logic [ROW_W-1:0] row_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
endpackage

// File: rtl/mc_chroma_ref_feeder_if.sv
// mc_chroma_ref_feeder_if: fetch-buffer read port plus the A..D row beat stream
interface mc_chroma_ref_feeder_if;
  import mc_chroma_ref_feeder_pkg::*;
  logic ref_rd_en_o;
  logic [ADDR_W-1:0] ref_rd_addr_o;
  row_t ref_rd_data_i;
  logic out_valid_o;
  logic out_ready_i;
  row_t out_a_o, out_b_o, out_c_o, out_d_o;
  modport master (
    output ref_rd_en_o, ref_rd_addr_o, out_valid_o, out_a_o, out_b_o, out_c_o, out_d_o,
    input ref_rd_data_i, out_ready_i
  );
  modport slave (
    input ref_rd_en_o, ref_rd_addr_o, out_valid_o, out_a_o, out_b_o, out_c_o, out_d_o,
    output ref_rd_data_i, out_ready_i
  );
endinterface

// File: rtl/mc_chroma_ref_feeder_row_window.sv
// mc_row_window: 4-row sliding window with one-entry hold register and loaded-row counter
module mc_row_window
  import mc_chroma_ref_feeder_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic single_i,
  input  logic rd_vld_i,
  input  row_t rd_data_i,
  input  logic ready_i,
  output logic valid_o,
  output logic hold_v_o,
  output row_t a_o,
  output row_t b_o,
  output row_t c_o,
  output row_t d_o
);
  row_t a_q, b_q, c_q, d_q, hold_q, din;
  logic valid_q, hold_v_q, accept, shift;
  logic [2:0] cnt_q, cnt_inc;
  always_comb begin
    accept = !valid_q || ready_i;
    shift = accept && (hold_v_q || rd_vld_i);
    din = hold_v_q ? hold_q : rd_data_i;
    cnt_inc = cnt_q == 3'd4 ? cnt_q : cnt_q + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      hold_q <= '0;
      hold_v_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (shift) begin
        a_q <= single_i ? '0 : b_q;
        b_q <= single_i ? din : c_q;
        c_q <= single_i ? '0 : d_q;
        d_q <= single_i ? '0 : din;
        cnt_q <= cnt_inc;
      end
      valid_q <= shift ? (single_i || cnt_inc == 3'd4) : valid_q && !ready_i;
      hold_v_q <= rd_vld_i ? (hold_v_q || !accept) : (hold_v_q && !accept);
      if (rd_vld_i && (hold_v_q || !accept)) hold_q <= rd_data_i;
    end
  end
  // a returning row must always find the hold slot free when the window is stalled
  assert property (@(posedge clk) disable iff (!rstn) !(rd_vld_i && hold_v_q && !accept));
  assign valid_o = valid_q;
  assign hold_v_o = hold_v_q;
  assign a_o = a_q;
  assign b_o = b_q;
  assign c_o = c_q;
  assign d_o = d_q;
endmodule

// File: rtl/mc_chroma_ref_feeder.sv
// mc_chroma_ref_feeder: job FSM and fetch-buffer address generation feeding the chroma 4-tap row window
module mc_chroma_ref_feeder
  import mc_chroma_ref_feeder_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [5:0] blk_h_i,
  input  logic [2:0] frac_x_i,
  input  logic [2:0] frac_y_i,
  output logic [2:0] frac_x_o,
  output logic [2:0] frac_y_o,
  output logic busy_o,
  output logic done_o,
  mc_chroma_ref_feeder_if.master bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] first_q;
  logic [5:0] blk_h_q, rd_cnt_q, beat_cnt_q, n_rows;
  logic [2:0] fx_q, fy_q;
  logic inflight_q, hold_v, issue, hs, go, single;
  always_comb begin
    single = fy_q == 3'd0;
    n_rows = blk_h_q + (single ? 6'd0 : 6'(TAPS));
    go = state_q == IDLE && start_i;
    hs = bus.out_valid_o && bus.out_ready_i;
    // never stack a second row behind a stalled beat: it would have nowhere to go
    issue = state_q == FETCH && !hold_v && !(inflight_q && bus.out_valid_o && !bus.out_ready_i);
    state_d = go ? FETCH
            : (issue && rd_cnt_q == n_rows - 6'd1) ? DRAIN
            : (state_q == DRAIN && hs && beat_cnt_q == blk_h_q - 6'd1) ? DONE
            : state_q == DONE ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      first_q <= '0;
      blk_h_q <= '0;
      rd_cnt_q <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      fx_q <= '0;
      fy_q <= '0;
    end else begin
      state_q <= state_d;
      inflight_q <= issue;
      if (go) begin
        first_q <= base_addr_i + ADDR_W'(frac_y_i == 3'd0);
        blk_h_q <= blk_h_i;
        fx_q <= frac_x_i;
        fy_q <= frac_y_i;
        rd_cnt_q <= '0;
        beat_cnt_q <= '0;
      end else begin
        rd_cnt_q <= rd_cnt_q + 6'(issue);
        beat_cnt_q <= beat_cnt_q + 6'(hs);
      end
    end
  end
  assign bus.ref_rd_en_o = issue;
  assign bus.ref_rd_addr_o = first_q + ADDR_W'(rd_cnt_q);
  assign frac_x_o = fx_q;
  assign frac_y_o = fy_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  mc_row_window u_win (
    .clk(clk),
    .rstn(rstn),
    .clr_i(go),
    .single_i(single),
    .rd_vld_i(inflight_q),
    .rd_data_i(bus.ref_rd_data_i),
    .ready_i(bus.out_ready_i),
    .valid_o(bus.out_valid_o),
    .hold_v_o(hold_v),
    .a_o(bus.out_a_o),
    .b_o(bus.out_b_o),
    .c_o(bus.out_c_o),
    .d_o(bus.out_d_o)
  );
endmodule

// File: tb/tb_mc_chroma_ref_feeder.sv
// tb_mc_chroma_ref_feeder: randomized jobs checked against a row-list model of the feeder
module tb_mc_chroma_ref_feeder;
  import mc_chroma_ref_feeder_pkg::*;
  typedef struct { row_t a; row_t b; row_t c; row_t d; int cyc; } beat_t;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [5:0] blk_h = 6'd2;
  logic [2:0] frac_x = '0, frac_y = '0, frac_x_o, frac_y_o;
  logic busy, done;
  int vectors = 0, miscompares = 0, cyc = 0, t0 = 0, done_cnt = 0, done_cyc = -1;
  row_t mem [256];
  int rd_addr_q[$], rd_cyc_q[$], exp_addr[$];
  beat_t bt_q[$], exp_q[$];
  mc_chroma_ref_feeder_if bus();
  mc_chroma_ref_feeder dut (
    .clk(clk), .rstn(rstn), .start_i(start), .base_addr_i(base_addr), .blk_h_i(blk_h),
    .frac_x_i(frac_x), .frac_y_i(frac_y), .frac_x_o(frac_x_o), .frac_y_o(frac_y_o),
    .busy_o(busy), .done_o(done), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.ref_rd_en_o) bus.ref_rd_data_i <= mem[bus.ref_rd_addr_o];
  always @(negedge clk) begin
    if (bus.ref_rd_en_o) begin
      rd_addr_q.push_back(int'(bus.ref_rd_addr_o));
      rd_cyc_q.push_back(cyc - t0);
    end
    if (bus.out_valid_o && bus.out_ready_i)
      bt_q.push_back('{bus.out_a_o, bus.out_b_o, bus.out_c_o, bus.out_d_o, cyc - t0});
    if (done) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
  end

  task automatic fill_rand();
    for (int r = 0; r < 256; r++)
      for (int w = 0; w < ROW_W / 32; w++) mem[r][w*32 +: 32] = $urandom();
  endtask

  // rows N and beats straight from the job rules; timing assumes ready held high
  task automatic model(input int base, input int bh, input int fy);
    int first, n;
    beat_t e;
    first = (base + (fy == 0 ? 1 : 0)) % 256;
    n = bh + (fy != 0 ? 3 : 0);
    exp_addr.delete();
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_addr.push_back((first + k) % 256);
    for (int j = 0; j < bh; j++) begin
      e.cyc = (fy != 0 ? 6 : 3) + j;
      e.a = fy != 0 ? mem[exp_addr[j]] : '0;
      e.b = fy != 0 ? mem[exp_addr[j+1]] : mem[exp_addr[j]];
      e.c = fy != 0 ? mem[exp_addr[j+2]] : '0;
      e.d = fy != 0 ? mem[exp_addr[j+3]] : '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_job(input int base, input int bh, input int fx, input int fy, input bit rnd, input bit spur);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    bt_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    base_addr = ADDR_W'(base);
    blk_h = 6'(bh);
    frac_x = 3'(fx);
    frac_y = 3'(fy);
    start = 1'b1;
    t0 = cyc;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      start = spur && busy && $urandom_range(0, 2) == 0;
      if (start) begin
        base_addr = ADDR_W'($urandom());
        blk_h = 6'($urandom_range(2, 32));
        frac_x = 3'($urandom());
        frac_y = 3'($urandom());
      end
      bus.out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, bus.ref_rd_en_o, bus.ref_rd_addr_o, bus.out_valid_o, frac_x_o, frac_y_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl got busy=%b done=%b en=%b addr=%h valid=%b fx=%0d fy=%0d, want all 0",
               busy, done, bus.ref_rd_en_o, bus.ref_rd_addr_o, bus.out_valid_o, frac_x_o, frac_y_o);
    end
    vectors++;
    if ({bus.out_a_o, bus.out_b_o, bus.out_c_o, bus.out_d_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got a=%h d=%h, want 0", bus.out_a_o, bus.out_d_o);
    end
    rstn = 1'b1;
  endtask

  task automatic test_tap_timing();
    for (int k = 0; k < 7; k++) mem[16 + k] = {REF_W{8'(k)}};
    model(16, 4, 3);
    run_job(16, 4, 2, 3, 1'b0, 1'b0);
    vectors++;
    if (rd_addr_q.size() != 7) begin
      miscompares++;
      $display("FAIL tap_rd_count got %0d want 7", rd_addr_q.size());
    end
    for (int k = 0; k < exp_addr.size() && k < rd_addr_q.size(); k++) begin
      vectors++;
      if (rd_addr_q[k] != exp_addr[k] || rd_cyc_q[k] != k + 1) begin
        miscompares++;
        $display("FAIL tap_rd%0d got addr %h cyc %0d want addr %h cyc %0d", k, rd_addr_q[k], rd_cyc_q[k], exp_addr[k], k + 1);
      end
    end
    vectors++;
    if (bt_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL tap_beat_count got %0d want %0d", bt_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < bt_q.size(); j++) begin
      vectors++;
      if ({bt_q[j].a, bt_q[j].b, bt_q[j].c, bt_q[j].d} !== {exp_q[j].a, exp_q[j].b, exp_q[j].c, exp_q[j].d} || bt_q[j].cyc != exp_q[j].cyc) begin
        miscompares++;
        $display("FAIL tap_beat%0d got cyc %0d a=%h d=%h want cyc %0d a=%h d=%h", j, bt_q[j].cyc, bt_q[j].a, bt_q[j].d, exp_q[j].cyc, exp_q[j].a, exp_q[j].d);
      end
    end
    vectors++;
    if (done_cyc != 10) begin
      miscompares++;
      $display("FAIL tap_done_cycle got %0d want 10", done_cyc);
    end
  endtask

  task automatic test_single_row();
    fill_rand();
    model(32, 8, 0);
    run_job(32, 8, 4, 0, 1'b0, 1'b0);
    vectors++;
    if (rd_addr_q.size() != 8 || (rd_addr_q.size() > 0 && rd_addr_q[0] != 33)) begin
      miscompares++;
      $display("FAIL single_reads got %0d reads want 8 from 0x21", rd_addr_q.size());
    end
    vectors++;
    if (bt_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_beat_count got %0d want %0d", bt_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < bt_q.size(); j++) begin
      vectors++;
      if ({bt_q[j].a, bt_q[j].b, bt_q[j].c, bt_q[j].d} !== {exp_q[j].a, exp_q[j].b, exp_q[j].c, exp_q[j].d} || bt_q[j].cyc != exp_q[j].cyc) begin
        miscompares++;
        $display("FAIL single_beat%0d got cyc %0d a=%h b=%h c=%h want cyc %0d b=%h", j, bt_q[j].cyc, bt_q[j].a, bt_q[j].b, bt_q[j].c, exp_q[j].cyc, exp_q[j].b);
      end
    end
    vectors++;
    if (done_cyc != 11) begin
      miscompares++;
      $display("FAIL single_done_cycle got %0d want 11", done_cyc);
    end
  endtask

  task automatic test_random_ready(input int base, input int fy, input string name);
    fill_rand();
    model(base, fy == 5 ? 16 : 4, fy);
    run_job(base, fy == 5 ? 16 : 4, 7, fy, fy == 5, 1'b0);
    vectors++;
    if (done_cnt != 1 || rd_addr_q.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL %s_reads got done=%0d reads=%0d want done=1 reads=%0d", name, done_cnt, rd_addr_q.size(), exp_addr.size());
    end
    for (int k = 0; k < exp_addr.size() && k < rd_addr_q.size(); k++) begin
      vectors++;
      if (rd_addr_q[k] != exp_addr[k]) begin
        miscompares++;
        $display("FAIL %s_rd%0d got %h want %h", name, k, rd_addr_q[k], exp_addr[k]);
      end
    end
    vectors++;
    if (bt_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_beat_count got %0d want %0d", name, bt_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < bt_q.size(); j++) begin
      vectors++;
      if ({bt_q[j].a, bt_q[j].b, bt_q[j].c, bt_q[j].d} !== {exp_q[j].a, exp_q[j].b, exp_q[j].c, exp_q[j].d}) begin
        miscompares++;
        $display("FAIL %s_beat%0d got a=%h d=%h want a=%h d=%h", name, j, bt_q[j].a, bt_q[j].d, exp_q[j].a, exp_q[j].d);
      end
    end
  endtask

  task automatic test_stall();
    row_t sa, sb, sc, sd;
    fill_rand();
    model(64, 8, 2);
    rd_addr_q.delete();
    bt_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    base_addr = 8'h40;
    blk_h = 6'd8;
    frac_x = 3'd1;
    frac_y = 3'd2;
    start = 1'b1;
    t0 = cyc;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 20 && !bus.out_valid_o; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    vectors++;
    if (bus.out_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_first_valid got %b want 1", bus.out_valid_o);
    end
    bus.out_ready_i = 1'b0;
    sa = bus.out_a_o;
    sb = bus.out_b_o;
    sc = bus.out_c_o;
    sd = bus.out_d_o;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid_o !== 1'b1 || {bus.out_a_o, bus.out_b_o, bus.out_c_o, bus.out_d_o} !== {sa, sb, sc, sd}) begin
        miscompares++;
        $display("FAIL stall_hold%0d got valid=%b a=%h d=%h want valid=1 a=%h d=%h", i, bus.out_valid_o, bus.out_a_o, bus.out_d_o, sa, sd);
      end
    end
    vectors++;
    if (rd_addr_q.size() > 5) begin
      miscompares++;
      $display("FAIL stall_reads got %0d reads want at most 5 (window plus one held)", rd_addr_q.size());
    end
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cnt != 1 || bt_q.size() != exp_q.size() || rd_addr_q.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL stall_resume got done=%0d beats=%0d reads=%0d want 1 %0d %0d", done_cnt, bt_q.size(), rd_addr_q.size(), exp_q.size(), exp_addr.size());
    end
    for (int j = 0; j < exp_q.size() && j < bt_q.size(); j++) begin
      vectors++;
      if ({bt_q[j].a, bt_q[j].b, bt_q[j].c, bt_q[j].d} !== {exp_q[j].a, exp_q[j].b, exp_q[j].c, exp_q[j].d}) begin
        miscompares++;
        $display("FAIL stall_beat%0d got a=%h d=%h want a=%h d=%h", j, bt_q[j].a, bt_q[j].d, exp_q[j].a, exp_q[j].d);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int nrd;
    fill_rand();
    model(96, 4, 2);
    rd_addr_q.delete();
    bt_q.delete();
    @(posedge clk); #1;
    base_addr = 8'h60;
    blk_h = 6'd4;
    frac_x = 3'd5;
    frac_y = 3'd2;
    start = 1'b1;
    t0 = cyc;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 30 && rd_addr_q.size() < 7; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    vectors++;
    if (busy !== 1'b1 || rd_addr_q.size() != 7) begin
      miscompares++;
      $display("FAIL rst_reach_drain got busy=%b reads=%0d want busy=1 reads=7", busy, rd_addr_q.size());
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, bus.ref_rd_en_o, bus.ref_rd_addr_o, bus.out_valid_o, frac_x_o, frac_y_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_ctrl_zero got busy=%b en=%b addr=%h valid=%b fx=%0d fy=%0d want all 0", busy, bus.ref_rd_en_o, bus.ref_rd_addr_o, bus.out_valid_o, frac_x_o, frac_y_o);
    end
    vectors++;
    if ({bus.out_a_o, bus.out_b_o, bus.out_c_o, bus.out_d_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_data_zero got a=%h b=%h want 0", bus.out_a_o, bus.out_b_o);
    end
    nrd = rd_addr_q.size();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (rd_addr_q.size() != nrd || busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_quiet got reads=%0d busy=%b valid=%b want reads=%0d busy=0 valid=0", rd_addr_q.size(), busy, bus.out_valid_o, nrd);
    end
    run_job(96, 4, 5, 2, 1'b0, 1'b0);
    vectors++;
    if (bt_q.size() != exp_q.size() || done_cyc != 10) begin
      miscompares++;
      $display("FAIL rst_rerun got beats=%0d done_cyc=%0d want %0d 10", bt_q.size(), done_cyc, exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < bt_q.size(); j++) begin
      vectors++;
      if ({bt_q[j].a, bt_q[j].b, bt_q[j].c, bt_q[j].d} !== {exp_q[j].a, exp_q[j].b, exp_q[j].c, exp_q[j].d} || bt_q[j].cyc != exp_q[j].cyc) begin
        miscompares++;
        $display("FAIL rst_rerun_beat%0d got cyc %0d a=%h want cyc %0d a=%h", j, bt_q[j].cyc, bt_q[j].a, exp_q[j].cyc, exp_q[j].a);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int base, bh, fx, fy;
    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, 255);
      bh = it == 0 ? 2 : $urandom_range(2, 32);
      fx = $urandom_range(0, 7);
      fy = it == 1 ? 0 : $urandom_range(1, 7);
      fill_rand();
      model(base, bh, fy);
      run_job(base, bh, fx, fy, 1'b1, 1'b1);
      vectors++;
      if (done_cnt != 1 || rd_addr_q.size() != exp_addr.size() || bt_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL spur%0d_counts got done=%0d reads=%0d beats=%0d want 1 %0d %0d", it, done_cnt, rd_addr_q.size(), bt_q.size(), exp_addr.size(), exp_q.size());
      end
      vectors++;
      if (frac_x_o !== 3'(fx) || frac_y_o !== 3'(fy)) begin
        miscompares++;
        $display("FAIL spur%0d_frac got fx=%0d fy=%0d want fx=%0d fy=%0d", it, frac_x_o, frac_y_o, fx, fy);
      end
      for (int j = 0; j < exp_q.size() && j < bt_q.size(); j++) begin
        vectors++;
        if ({bt_q[j].a, bt_q[j].b, bt_q[j].c, bt_q[j].d} !== {exp_q[j].a, exp_q[j].b, exp_q[j].c, exp_q[j].d}) begin
          miscompares++;
          $display("FAIL spur%0d_beat%0d got a=%h b=%h want a=%h b=%h", it, j, bt_q[j].a, bt_q[j].b, exp_q[j].a, exp_q[j].b);
        end
      end
    end
  endtask

  initial begin
    bus.out_ready_i = 1'b1;
    test_reset();
    test_tap_timing();
    test_single_row();
    test_random_ready(128, 5, "rnd_ready");
    test_stall();
    test_random_ready(254, 1, "wrap");
    test_reset_mid_drain();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_chroma_ref_feeder.md
# mc_chroma_ref_feeder

Row-streaming source for the chroma 4-tap interpolation datapath in rec_mc. It reads reference chroma rows from the MC fetch buffer, which is a synchronous-read SRAM with one row per word. It maintains a 4-row sliding window and emits one valid/ready beat per output row. Each beat carries rows A/B/C/D, which feed the horizontal filters and, after them, the vertical filter.

## Interface
- PIXEL_WIDTH, 8, bits per sample (from `enc_defines.v`)
- REF_W, 20, samples per fetched row (max block width 16 + 3 taps, padded)
- ADDR_W, 8, fetch-buffer row address width
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low, sampled on rising clk
- start_i  in  1  one-cycle job start; ignored unless IDLE
- base_addr_i  in  ADDR_W  address of the row one above the block (tap A row)
- blk_h_i  in  6  block height in rows, 2..32; 0 and 1 are illegal
- frac_x_i, frac_y_i  in  3 each  eighth-pel fractions, latched at start
- ref_rd_en_o  out  1  SRAM read enable
- ref_rd_addr_o  out  ADDR_W  SRAM row address
- ref_rd_data_i  in  REF_W*PIXEL_WIDTH  read data, valid the cycle after ref_rd_en_o
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  consumer ready
- out_a_o, out_b_o, out_c_o, out_d_o  out  REF_W*PIXEL_WIDTH each  window rows, oldest (A) to newest (D)
- frac_x_o, frac_y_o  out  3 each  latched fractions, stable while busy
- busy_o  out  1  high from the cycle after an accepted start through DONE
- done_o  out  1  one-cycle pulse after the last beat handshake

## Operation
- States and transitions:
  - IDLE → FETCH on start_i.
  - FETCH → DRAIN when the last read has issued.
  - DRAIN → DONE when the last beat handshakes.
  - DONE → IDLE unconditionally. DONE lasts one cycle and asserts done_o.
- Row count N and first address:
  - frac_y≠0: N = blk_h+3, first address = base_addr.
  - frac_y=0: N = blk_h, first address = base_addr+1. In this mode only the B row is meaningful; A, C and D are driven to 0.
- Read k goes to first address + k, for k = 0..N-1. Address arithmetic wraps modulo 2^ADDR_W.
- Window shift: a new row enters at D, D→C, C→B, B→A.
- A beat exists when the loaded-row count reaches 4 (frac_y≠0) or 1 (frac_y=0). Every later shift produces a new beat. Total beats per job = blk_h.
- Window accept condition: out_valid_o=0, or out_ready_i=1.
- A returned row that cannot be accepted goes into a one-entry hold register. The hold register has priority over fresh data.
- Read issue condition: in FETCH, hold empty, and NOT (a read is in flight AND out_valid_o AND !out_ready_i). This guarantees no row is ever lost or duplicated.
- start_i while not IDLE is ignored.
- rstn low in any state: return to IDLE next edge, drop any in-flight read, and clear hold.

## Timing
- Reset values: all outputs 0; state IDLE.
- start_i sampled in cycle 0. Reads issue in cycles 1..N with out_ready_i held high.
- frac_y≠0, out_ready_i held high:
  - First beat in cycle 6; beats in cycles 6..blk_h+5.
  - done_o in cycle blk_h+6.
- frac_y=0, out_ready_i held high:
  - Beats in cycles 3..blk_h+2; done_o in cycle blk_h+3.
- Throughput: 1 beat per cycle with no stalls.
- Output data and valid are registered. While out_valid_o=1 and out_ready_i=0, all out_* outputs hold stable.
- busy_o falls in the cycle after DONE.

## Structure
- Shared package/defines: PIXEL_WIDTH, REF_W, state encodings (IDLE/FETCH/DRAIN/DONE), and the tap-count constant 3.
- One sub-module is natural: mc_row_window, which holds the 4-row shift register, the hold register and the loaded-row counter. The FSM and address generation stay in the top module.

## Test plan
- frac_y=3, blk_h=4, base=0x10, SRAM row k holds fill byte k, ready always high:
  - reads go to 0x10..0x16.
  - beat j has A..D equal to fills j..j+3, for j = 0..3.
  - beats in cycles 6..9; done_o in cycle 10.
- frac_y=0, blk_h=8, base=0x20:
  - 8 reads starting at 0x21.
  - each beat has B = row, and A, C, D = 0.
  - beats in cycles 3..10.
- frac_y=5, blk_h=16, ready toggles by random pattern:
  - exactly 16 beats, in order, no duplicates.
  - read count = 19.
  - hold never overflows (assertion).
- ready held low for 10 cycles after the first beat:
  - outputs are stable throughout.
  - reads stop with at most one row in hold.
  - the stream resumes correctly.
- base=0xFE, frac_y=1, blk_h=4: addresses wrap to 0xFE, 0xFF, 0x00..0x04.
- Reset and start-while-busy:
  - rstn low mid-DRAIN: all outputs are 0 next cycle and no further reads issue.
  - a new start then runs normally.
  - start_i asserted while busy is ignored.
